// File: rtl/periph_rx_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// lycan_globals
//   Shared constants and types for the peripheral return path.
//   - usb_packet_width     : width of one word travelling toward the USB bridge
//   - periph_address_width : width of the address tag carried in the top bits
//   - num_periphs          : default number of peripheral instances
//   - rx_arb_state_t       : states of the RX return-path arbiter
//   - rr_wrap()            : modular index helper for round-robin searches
// ---------------------------------------------------------------------------
package lycan_globals;

    localparam int usb_packet_width     = 32;
    localparam int periph_address_width = 4;
    localparam int num_periphs          = 4;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_READ,
        ARB_CAPTURE,
        ARB_SEND
    } rx_arb_state_t;

    // (base + off) mod n, used to walk requesters starting after the pointer.
    function automatic int rr_wrap(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/periph_rx_arbiter_if.sv
// ---------------------------------------------------------------------------
// periph_rx_arbiter_if
//   Bundles the per-peripheral RX FIFO signals, the outgoing valid/ready
//   stream and the grant status of the RX return-path arbiter.
//   master : the arbiter (pops FIFOs, drives the stream and grant status)
//   slave  : the surroundings (FIFOs, peripherals, USB bridge)
//   Signals:
//     rx_data        per-periph FIFO dout (registered, 1-cycle read latency)
//     rx_empty       per-periph FIFO empty
//     rx_almost_full per-periph FIFO programmable-full
//     periph_ready   per-periph post-reset ready flag
//     rx_read        one-hot pop strobe
//     out_data/out_valid/out_ready  stream toward USB
//     grant_valid/grant_id          current grant status
// ---------------------------------------------------------------------------
interface periph_rx_arbiter_if
    import lycan_globals::*;
#(
    parameter int NUM_PERIPHS = num_periphs,
    parameter int DATA_W      = usb_packet_width
);
    localparam int IW = (NUM_PERIPHS > 1) ? $clog2(NUM_PERIPHS) : 1;

    logic [DATA_W-1:0]      rx_data [NUM_PERIPHS];
    logic [NUM_PERIPHS-1:0] rx_empty;
    logic [NUM_PERIPHS-1:0] rx_almost_full;
    logic [NUM_PERIPHS-1:0] periph_ready;
    logic [NUM_PERIPHS-1:0] rx_read;
    logic [DATA_W-1:0]      out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic                   grant_valid;
    logic [IW-1:0]          grant_id;

    modport master (
        input  rx_data, rx_empty, rx_almost_full, periph_ready, out_ready,
        output rx_read, out_data, out_valid, grant_valid, grant_id
    );

    modport slave (
        output rx_data, rx_empty, rx_almost_full, periph_ready, out_ready,
        input  rx_read, out_data, out_valid, grant_valid, grant_id
    );

endinterface

// File: rtl/periph_rx_arbiter_rr.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin picker.
//   Ports:
//     req       in  N   request vector
//     ptr       in  IW  index of the last winner; search starts at ptr+1
//     grant     out N   one-hot winner (zero when nothing requested)
//     grant_idx out IW  index of the winner (zero when nothing requested)
//     any       out 1   at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter
    import lycan_globals::*;
#(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any
);

    logic [IW-1:0] idx;

    // Walk offsets from the far end down to 1 so that the requester closest
    // after the pointer is the last one written, i.e. the winner.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = '0;
        for (int off = N; off >= 1; off--) begin
            idx = IW'(rr_wrap(int'(ptr), off, N));
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = idx;
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/periph_rx_arbiter.sv
// ---------------------------------------------------------------------------
// periph_rx_arbiter
//   Shares the single USB return path among NUM_PERIPHS peripheral RX FIFOs.
//   Pops one word at a time from the granted FIFO and forwards it on a
//   valid/ready stream. Round-robin with a per-grant burst cap of MAX_BURST
//   words; peripherals whose FIFO is almost full are served first.
//   Ports:
//     clk  in  system clock
//     rst  in  asynchronous active-high reset
//     bus  master side of periph_rx_arbiter_if (FIFO pops, stream, grant)
//   One word is in flight at most: IDLE -> READ (pop) -> CAPTURE (FIFO dout
//   valid) -> SEND (hold until handshake), so beats are >= 3 cycles apart.
// ---------------------------------------------------------------------------
module periph_rx_arbiter
    import lycan_globals::*;
#(
    parameter int NUM_PERIPHS = num_periphs,
    parameter int MAX_BURST   = 4
) (
    input  logic                clk,
    input  logic                rst,
    periph_rx_arbiter_if.master bus
);

    localparam int IW = (NUM_PERIPHS > 1) ? $clog2(NUM_PERIPHS) : 1;
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int DW = usb_packet_width;

    // ---------------- request qualification ----------------
    logic [NUM_PERIPHS-1:0] eligible;
    logic [NUM_PERIPHS-1:0] urgent;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PERIPHS; gi++) begin : g_req
            assign eligible[gi] = !bus.rx_empty[gi] && bus.periph_ready[gi];
            assign urgent[gi]   = eligible[gi] && bus.rx_almost_full[gi];
        end
    endgenerate

    // ---------------- state ----------------
    rx_arb_state_t          state_reg,       state_next;
    logic [IW-1:0]          ptr_reg,         ptr_next;
    logic [BW-1:0]          beat_reg,        beat_next;
    logic [IW-1:0]          grant_id_reg,    grant_id_next;
    logic [NUM_PERIPHS-1:0] grant_oh_reg,    grant_oh_next;
    logic                   grant_valid_reg, grant_valid_next;
    logic [DW-1:0]          out_data_reg,    out_data_next;
    logic                   out_valid_reg,   out_valid_next;

    // ---------------- winner selection ----------------
    logic [NUM_PERIPHS-1:0] urg_oh,  elig_oh,  win_oh;
    logic [IW-1:0]          urg_idx, elig_idx, win_idx;
    logic                   urg_any, elig_any;

    rr_arbiter #(.N(NUM_PERIPHS), .IW(IW)) u_rr_urgent (
        .req       (urgent),
        .ptr       (ptr_reg),
        .grant     (urg_oh),
        .grant_idx (urg_idx),
        .any       (urg_any)
    );

    rr_arbiter #(.N(NUM_PERIPHS), .IW(IW)) u_rr_eligible (
        .req       (eligible),
        .ptr       (ptr_reg),
        .grant     (elig_oh),
        .grant_idx (elig_idx),
        .any       (elig_any)
    );

    // Any urgent requester is also eligible, so the urgent pick is always a
    // legal winner when present.
    assign win_oh  = urg_any ? urg_oh  : elig_oh;
    assign win_idx = urg_any ? urg_idx : elig_idx;

    // ---------------- burst continuation ----------------
    logic [BW-1:0] beat_inc;
    logic          grant_more;

    assign beat_inc   = beat_reg + BW'(1);
    // Evaluated at the handshake: the pop for the current word happened two
    // cycles earlier, so rx_empty already reflects what is left.
    assign grant_more = !bus.rx_empty[grant_id_reg] && bus.periph_ready[grant_id_reg];

    // ---------------- next-state / datapath ----------------
    always_comb begin
        state_next       = state_reg;
        ptr_next         = ptr_reg;
        beat_next        = beat_reg;
        grant_id_next    = grant_id_reg;
        grant_oh_next    = grant_oh_reg;
        grant_valid_next = grant_valid_reg;
        out_data_next    = out_data_reg;
        out_valid_next   = out_valid_reg;

        case (state_reg)
            ARB_IDLE: begin
                if (elig_any) begin
                    grant_id_next    = win_idx;
                    grant_oh_next    = win_oh;
                    grant_valid_next = 1'b1;
                    beat_next        = '0;
                    state_next       = ARB_READ;
                end
            end

            ARB_READ: begin
                state_next = ARB_CAPTURE;
            end

            ARB_CAPTURE: begin
                out_data_next  = bus.rx_data[grant_id_reg];
                out_valid_next = 1'b1;
                state_next     = ARB_SEND;
            end

            ARB_SEND: begin
                if (out_valid_reg && bus.out_ready) begin
                    out_valid_next = 1'b0;
                    out_data_next  = '0;
                    beat_next      = beat_inc;
                    if ((beat_inc < BW'(MAX_BURST)) && grant_more) begin
                        state_next = ARB_READ;
                    end else begin
                        ptr_next         = grant_id_reg;
                        grant_valid_next = 1'b0;
                        state_next       = ARB_IDLE;
                    end
                end
            end

            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= ARB_IDLE;
            ptr_reg         <= IW'(NUM_PERIPHS - 1);
            beat_reg        <= '0;
            grant_id_reg    <= '0;
            grant_oh_reg    <= '0;
            grant_valid_reg <= 1'b0;
            out_data_reg    <= '0;
            out_valid_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            ptr_reg         <= ptr_next;
            beat_reg        <= beat_next;
            grant_id_reg    <= grant_id_next;
            grant_oh_reg    <= grant_oh_next;
            grant_valid_reg <= grant_valid_next;
            out_data_reg    <= out_data_next;
            out_valid_reg   <= out_valid_next;
        end
    end

    // ---------------- outputs ----------------
    // The pop strobe is decoded from state so that an asynchronous reset
    // removes it in the same instant as the state register clears.
    generate
        for (gi = 0; gi < NUM_PERIPHS; gi++) begin : g_rd
            assign bus.rx_read[gi] = (state_reg == ARB_READ) && grant_oh_reg[gi];
        end
    endgenerate

    assign bus.out_data    = out_data_reg;
    assign bus.out_valid   = out_valid_reg;
    assign bus.grant_valid = grant_valid_reg;
    assign bus.grant_id    = grant_id_reg;

endmodule
